seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receive end of the team's hex-to-7-segment path: monitors a multiplexed 7-segment display bus (segments plus one-hot digit enables) and recovers the hex value shown on each digit.
- Used as a display-readback checker and loopback monitor beside the display driver.
- Each captured pattern must hold stable for a programmable dwell before it is accepted.
- Outputs per-digit hex, valid and invalid-code flags, plus an update strobe and a frame-complete strobe.

Parameters:
- NUM_DIGITS, 4, number of scanned digits; legal range 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before capture; must be at least 1.

Ports:
- clock  in  1  Single system clock; all state updates on the rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- seg  in  7  Segment bus, active-high, synchronous to clock; bit0=a, bit1=b, ... bit6=g.
- digit_en  in  NUM_DIGITS  Digit enables, active-high, expected one-hot.
- hex  out  4*NUM_DIGITS  Recovered values; digit i occupies bits 4i+3:4i.
- digit_valid  out  NUM_DIGITS  Set once digit i has been captured at least once.
- code_err  out  NUM_DIGITS  Set when the last capture of digit i was not a legal code.
- update  out  1  One-cycle pulse on each capture.
- upd_digit  out  3  Index of the digit captured; meaningful only while update=1.
- frame_done  out  1  One-cycle pulse when every digit has been captured since the previous frame_done or reset.

Behaviour:
- Reset, while reset_n=0: all outputs, the sample registers, the counter and the frame mask clear to 0. The FSM returns to IDLE immediately; an in-progress dwell is abandoned.
- Stage 1: seg and digit_en are registered every cycle (s_seg, s_en).
- Stage 2 FSM:
  - IDLE: wait while s_en is not one-hot. On a one-hot s_en, load cnt=1 and go to SETTLE.
  - SETTLE: if (s_seg,s_en) equals the previous sample, cnt increments. When cnt reaches STABLE_CYCLES, capture on that edge and go to CAPTURED. Any change reloads cnt=1, or goes to IDLE if the new s_en is not one-hot.
  - CAPTURED: hold with no further captures while the sample stays unchanged (one capture per dwell). On any change, behave as SETTLE's change rule.
- Latency: inputs constant from before rising edge 1 give update=1 for the cycle after edge STABLE_CYCLES+1. hex, digit_valid and code_err are updated on that same edge.
- STABLE_CYCLES=1: capture on the first edge at which s_en is one-hot.
- Capture actions:
  - Write the decoded nibble into the hex slot for digit i, or write 0 if the code is illegal.
  - Set digit_valid[i].
  - Set code_err[i] if the code is illegal, clear it if legal.
  - Pulse update and drive upd_digit=i.
  - Set frame mask bit i.
- Legal codes, as 7-bit seg values:
  - 0x00 decodes to 0; the team encoder blanks zero. 0x3F also decodes to 0.
  - 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07.
  - 8=0x7F, 9=0x6F, A=0x77, B=0x7C, C=0x39, D=0x5E, E=0x79, F=0x71.
  - All other patterns are illegal.
- Frame completion: when the frame mask becomes all ones, frame_done pulses in the same cycle as that capture's update, and the mask clears to 0 on the same edge.
- Multi-hot or zero digit_en: no capture, cnt cleared, existing outputs held.
- Re-capturing the same digit before the frame completes: outputs overwrite, frame mask unchanged.
- Widths: cnt is wide enough to hold STABLE_CYCLES and saturates there. upd_digit is zero-extended to 3 bits.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16 segment-code constants (SEG7_CODE_0..SEG7_CODE_F, plus SEG7_CODE_0_ALT=0x3F);
  - segment bit-position constants;
  - the FSM state encoding (IDLE, SETTLE, CAPTURED).
- One combinational sub-module, seg7_to_hex: input seg[6:0]; outputs hex[3:0] and legal. Instantiated once in stage 2.

Test Plan (NUM_DIGITS=4, STABLE_CYCLES=4):
- Reset release; seg=0x5B, digit_en=0001 held 8 cycles -> update pulses once, in the cycle after edge 5. upd_digit=0, hex[3:0]=2, digit_valid=0001, code_err=0000.
- Scan digits 0..3 with codes 0x06, 0x00, 0x71, 0x39, 6 cycles each -> four update pulses. hex=0xCF01. frame_done coincides with the digit-3 update; digit_valid=1111.
- Digit 1 with seg toggling 0x7F/0x6F every 2 cycles for 20 cycles -> no update; hex and digit_valid unchanged.
- digit_en=0110 held with seg=0x07 for 10 cycles -> no update, no state change; then digit_en=0100 for 6 cycles -> capture, hex[11:8]=7.
- seg=0x01 on digit 2 for 6 cycles -> update=1, code_err[2]=1, hex[11:8]=0; then seg=0x79 -> code_err[2]=0, hex[11:8]=E.
- reset_n pulled low for 1 cycle at cnt=3 of a dwell -> all outputs 0 immediately. After release, the same held input needs a full 5-edge dwell before update.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the 7-segment readback path.
//   - Segment bit positions on the seg bus (bit0=a ... bit6=g).
//   - The 16 hex segment codes produced by the team encoder, plus the
//     alternate (lit) zero pattern.
//   - Scan FSM state encoding.
//   - Small helpers for one-hot checking / index recovery on enable vectors
//     (up to 8 digits, callers zero-extend narrower vectors).
// -----------------------------------------------------------------------------
package seg7_pkg;

  // Segment bit positions on the seg bus
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Hex segment codes. The encoder blanks a zero digit, so the primary code
  // for 0 is all-off; the fully lit zero is accepted as an alternate.
  localparam logic [6:0] SEG7_CODE_0     = 7'h00;
  localparam logic [6:0] SEG7_CODE_0_ALT = 7'h3F;
  localparam logic [6:0] SEG7_CODE_1     = 7'h06;
  localparam logic [6:0] SEG7_CODE_2     = 7'h5B;
  localparam logic [6:0] SEG7_CODE_3     = 7'h4F;
  localparam logic [6:0] SEG7_CODE_4     = 7'h66;
  localparam logic [6:0] SEG7_CODE_5     = 7'h6D;
  localparam logic [6:0] SEG7_CODE_6     = 7'h7D;
  localparam logic [6:0] SEG7_CODE_7     = 7'h07;
  localparam logic [6:0] SEG7_CODE_8     = 7'h7F;
  localparam logic [6:0] SEG7_CODE_9     = 7'h6F;
  localparam logic [6:0] SEG7_CODE_A     = 7'h77;
  localparam logic [6:0] SEG7_CODE_B     = 7'h7C;
  localparam logic [6:0] SEG7_CODE_C     = 7'h39;
  localparam logic [6:0] SEG7_CODE_D     = 7'h5E;
  localparam logic [6:0] SEG7_CODE_E     = 7'h79;
  localparam logic [6:0] SEG7_CODE_F     = 7'h71;

  // Scan FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURED = 2'd2
  } scan_state_t;

  // True when exactly one bit of v is set
  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Index of the set bit of a one-hot vector (result is undefined-but-safe
  // for non one-hot input; callers only use it when is_onehot8 holds)
  function automatic logic [2:0] onehot_index8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// -----------------------------------------------------------------------------
// seg7_to_hex
//   Combinational inverse of the team hex-to-7-segment encoder.
//   Ports:
//     seg   in  [6:0]  segment pattern, active-high, bit0=a ... bit6=g
//     hex   out [3:0]  decoded nibble (0 when the pattern is not a legal code)
//     legal out        1 when seg is one of the recognised codes
// -----------------------------------------------------------------------------
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       legal
);

  always_comb begin
    hex   = 4'h0;
    legal = 1'b1;
    case (seg)
      SEG7_CODE_0,
      SEG7_CODE_0_ALT: hex = 4'h0;
      SEG7_CODE_1:     hex = 4'h1;
      SEG7_CODE_2:     hex = 4'h2;
      SEG7_CODE_3:     hex = 4'h3;
      SEG7_CODE_4:     hex = 4'h4;
      SEG7_CODE_5:     hex = 4'h5;
      SEG7_CODE_6:     hex = 4'h6;
      SEG7_CODE_7:     hex = 4'h7;
      SEG7_CODE_8:     hex = 4'h8;
      SEG7_CODE_9:     hex = 4'h9;
      SEG7_CODE_A:     hex = 4'hA;
      SEG7_CODE_B:     hex = 4'hB;
      SEG7_CODE_C:     hex = 4'hC;
      SEG7_CODE_D:     hex = 4'hD;
      SEG7_CODE_E:     hex = 4'hE;
      SEG7_CODE_F:     hex = 4'hF;
      default: begin
        hex   = 4'h0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//   Monitors a multiplexed 7-segment bus and recovers the hex value shown on
//   each digit. A (segment, enable) pattern must stay identical for
//   STABLE_CYCLES consecutive samples before it is captured; one capture is
//   made per dwell.
//   Parameters:
//     NUM_DIGITS     number of scanned digits (1..8)
//     STABLE_CYCLES  identical samples required before capture (>= 1)
//   Ports:
//     clock        in   system clock, rising edge
//     reset_n      in   asynchronous active-low reset
//     seg          in   [6:0] segment bus, bit0=a ... bit6=g
//     digit_en     in   [NUM_DIGITS-1:0] digit enables, expected one-hot
//     hex          out  [4*NUM_DIGITS-1:0] recovered nibble per digit
//     digit_valid  out  [NUM_DIGITS-1:0] digit captured at least once
//     code_err     out  [NUM_DIGITS-1:0] last capture of digit was illegal
//     update       out  one-cycle pulse per capture
//     upd_digit    out  [2:0] digit index of the capture (valid with update)
//     frame_done   out  one-cycle pulse when every digit has been captured
// -----------------------------------------------------------------------------
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [4*NUM_DIGITS-1:0] hex,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   code_err,
  output logic                    update,
  output logic [2:0]              upd_digit,
  output logic                    frame_done
);

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  // With a one-sample dwell the first one-hot sample is captured directly.
  localparam bit              ONE_SHOT = (STABLE_CYCLES == 1);

  // ---------------------------------------------------------------------------
  // Stage 1: sample the bus, and keep the previous sample for change detection
  // ---------------------------------------------------------------------------
  logic [6:0]            s_seg_reg;
  logic [NUM_DIGITS-1:0] s_en_reg;
  logic [6:0]            p_seg_reg;
  logic [NUM_DIGITS-1:0] p_en_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_seg_reg <= '0;
      s_en_reg  <= '0;
      p_seg_reg <= '0;
      p_en_reg  <= '0;
    end else begin
      s_seg_reg <= seg;
      s_en_reg  <= digit_en;
      p_seg_reg <= s_seg_reg;
      p_en_reg  <= s_en_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 helpers
  // ---------------------------------------------------------------------------
  logic [7:0] en_wide;
  logic       en_onehot;
  logic [2:0] cap_index;
  logic       same;
  logic [3:0] dec_hex;
  logic       dec_legal;

  always_comb begin
    en_wide                 = 8'd0;
    en_wide[NUM_DIGITS-1:0] = s_en_reg;
  end

  assign en_onehot = is_onehot8(en_wide);
  assign cap_index = onehot_index8(en_wide);
  assign same      = (s_seg_reg == p_seg_reg) && (s_en_reg == p_en_reg);

  seg7_to_hex u_dec (
    .seg   (s_seg_reg),
    .hex   (dec_hex),
    .legal (dec_legal)
  );

  // ---------------------------------------------------------------------------
  // Capture condition for the current edge: either the dwell counter is about
  // to reach its target, or (one-sample dwell) a fresh one-hot sample arrives.
  // ---------------------------------------------------------------------------
  scan_state_t   state_reg;
  logic [CW-1:0] cnt_reg;
  logic          capture;

  always_comb begin
    capture = 1'b0;
    case (state_reg)
      ST_IDLE:     capture = ONE_SHOT && en_onehot;
      ST_SETTLE:   capture = same ? (cnt_reg == CNT_MAX - CNT_ONE)
                                  : (ONE_SHOT && en_onehot);
      ST_CAPTURED: capture = !same && ONE_SHOT && en_onehot;
      default:     capture = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2 FSM with registered strobes and frame tracking
  // ---------------------------------------------------------------------------
  logic                  update_reg;
  logic [2:0]            upd_digit_reg;
  logic                  frame_done_reg;
  logic [NUM_DIGITS-1:0] mask_reg;
  logic [NUM_DIGITS-1:0] mask_next;

  // s_en_reg is one-hot whenever a capture happens
  assign mask_next = mask_reg | s_en_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      update_reg     <= 1'b0;
      upd_digit_reg  <= 3'd0;
      frame_done_reg <= 1'b0;
      mask_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (en_onehot) begin
            cnt_reg   <= CNT_ONE;
            state_reg <= ONE_SHOT ? ST_CAPTURED : ST_SETTLE;
          end else begin
            cnt_reg   <= '0;
          end
        end
        ST_SETTLE, ST_CAPTURED: begin
          if (same) begin
            // Count up to the target; saturate while the dwell continues.
            if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_ONE;
            if (state_reg == ST_SETTLE && cnt_reg == CNT_MAX - CNT_ONE)
              state_reg <= ST_CAPTURED;
          end else if (en_onehot) begin
            cnt_reg   <= CNT_ONE;
            state_reg <= ONE_SHOT ? ST_CAPTURED : ST_SETTLE;
          end else begin
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase

      update_reg     <= capture;
      frame_done_reg <= capture && (&mask_next);
      if (capture) begin
        upd_digit_reg <= cap_index;
        mask_reg      <= (&mask_next) ? '0 : mask_next;
      end
    end
  end

  assign update     = update_reg;
  assign upd_digit  = upd_digit_reg;
  assign frame_done = frame_done_reg;

  // ---------------------------------------------------------------------------
  // Per-digit result registers
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] hex_reg;
      logic       valid_reg;
      logic       err_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          hex_reg   <= 4'h0;
          valid_reg <= 1'b0;
          err_reg   <= 1'b0;
        end else if (capture && s_en_reg[gi]) begin
          hex_reg   <= dec_legal ? dec_hex : 4'h0;
          valid_reg <= 1'b1;
          err_reg   <= !dec_legal;
        end
      end

      assign hex[4*gi +: 4]  = hex_reg;
      assign digit_valid[gi] = valid_reg;
      assign code_err[gi]    = err_reg;
    end
  endgenerate

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//   Self-checking bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
//   The reference model tracks the run length of identical input samples:
//   a capture is due one edge after an input sample that completes a run of
//   exactly STABLE_CYCLES identical one-hot samples.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clock;
  logic          reset_n;
  logic [6:0]    seg;
  logic [ND-1:0] digit_en;
  logic [4*ND-1:0] hex;
  logic [ND-1:0] digit_valid;
  logic [ND-1:0] code_err;
  logic          update;
  logic [2:0]    upd_digit;
  logic          frame_done;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .seg         (seg),
    .digit_en    (digit_en),
    .hex         (hex),
    .digit_valid (digit_valid),
    .code_err    (code_err),
    .update      (update),
    .upd_digit   (upd_digit),
    .frame_done  (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  logic [6:0]  codes [16];
  logic [15:0] m_hex;
  logic [3:0]  m_valid, m_err, m_mask;
  logic        m_upd, m_frame;
  logic [2:0]  m_upd_digit;
  int          run_len;
  logic [6:0]  run_seg;
  logic [3:0]  run_en;
  logic        pend;
  int          pend_idx;
  logic [6:0]  pend_seg;

  int total, bad, upd_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic lookup(input logic [6:0] sv, output logic [3:0] nib, output logic ok);
    nib = 4'h0;
    ok  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sv == codes[i]) begin
        nib = 4'(i);
        ok  = 1'b1;
      end
    end
    if (sv == 7'h3F) begin
      nib = 4'h0;
      ok  = 1'b1;
    end
  endtask

  task automatic model_clear();
    m_hex = '0; m_valid = '0; m_err = '0; m_mask = '0;
    m_upd = 1'b0; m_frame = 1'b0; m_upd_digit = 3'd0;
    run_len = 0; run_seg = '0; run_en = '0;
    pend = 1'b0; pend_idx = 0; pend_seg = '0;
  endtask

  task automatic compare_all();
    check("update", {31'd0, update}, {31'd0, m_upd});
    if (m_upd) check("upd_digit", {29'd0, upd_digit}, {29'd0, m_upd_digit});
    check("frame_done", {31'd0, frame_done}, {31'd0, m_frame});
    check("hex", {16'd0, hex}, {16'd0, m_hex});
    check("digit_valid", {28'd0, digit_valid}, {28'd0, m_valid});
    check("code_err", {28'd0, code_err}, {28'd0, m_err});
  endtask

  // One clock cycle: drive at the falling edge, advance the model at the
  // rising edge, compare at the next falling edge.
  task automatic tick(input logic [6:0] sv, input logic [3:0] ev);
    logic [3:0] nib;
    logic       ok;
    seg      = sv;
    digit_en = ev;
    @(posedge clock);
    m_upd   = pend;
    m_frame = 1'b0;
    if (pend) begin
      lookup(pend_seg, nib, ok);
      m_upd_digit = 3'(pend_idx);
      m_hex[pend_idx*4 +: 4] = ok ? nib : 4'h0;
      m_valid[pend_idx] = 1'b1;
      m_err[pend_idx]   = !ok;
      m_mask[pend_idx]  = 1'b1;
      if (m_mask == 4'hF) begin
        m_frame = 1'b1;
        m_mask  = 4'h0;
      end
    end
    if (run_len > 0 && sv == run_seg && ev == run_en) begin
      if (run_len < 1000) run_len++;
    end else begin
      run_len = 1;
      run_seg = sv;
      run_en  = ev;
    end
    pend     = ($countones(ev) == 1) && (run_len == SC);
    pend_seg = sv;
    pend_idx = 0;
    for (int i = 0; i < ND; i++) if (ev[i]) pend_idx = i;
    @(negedge clock);
    compare_all();
    if (update) begin
      upd_seen++;
      $display("capture digit=%0d hex=%h valid=%b err=%b frame=%0d",
               upd_digit, hex, digit_valid, code_err, frame_done);
    end
  endtask

  task automatic hold(input logic [6:0] sv, input logic [3:0] ev, input int n);
    for (int i = 0; i < n; i++) tick(sv, ev);
  endtask

  // Asynchronous reset pulse of one cycle, asserted mid-cycle
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_clear();
    compare_all();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    codes = '{7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    total = 0; bad = 0; upd_seen = 0;
    reset_n = 1'b0; seg = '0; digit_en = '0;
    model_clear();
    repeat (2) @(negedge clock);
    compare_all();
    reset_n = 1'b1;

    // Single digit, constant input: exactly one capture
    upd_seen = 0;
    hold(7'h5B, 4'b0001, 8);
    check("first_upd_count", upd_seen, 1);
    check("first_hex0", {28'd0, hex[3:0]}, 32'h2);

    // Scan all four digits
    hold(7'h06, 4'b0001, 6);
    hold(7'h00, 4'b0010, 6);
    hold(7'h71, 4'b0100, 6);
    hold(7'h39, 4'b1000, 6);
    check("scan_hex", {16'd0, hex}, 32'hCF01);
    check("scan_valid", {28'd0, digit_valid}, 32'hF);

    // Toggling segments never settle
    upd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      hold(7'h7F, 4'b0010, 2);
      hold(7'h6F, 4'b0010, 2);
    end
    check("toggle_no_upd", upd_seen, 0);

    // Multi-hot enable is ignored, then a clean one-hot dwell
    upd_seen = 0;
    hold(7'h07, 4'b0110, 10);
    check("multihot_no_upd", upd_seen, 0);
    hold(7'h07, 4'b0100, 6);
    check("d2_hex7", {28'd0, hex[11:8]}, 32'h7);

    // Illegal code then legal code on digit 2
    hold(7'h01, 4'b0100, 6);
    check("d2_err", {31'd0, code_err[2]}, 32'h1);
    hold(7'h79, 4'b0100, 6);
    check("d2_hexE", {28'd0, hex[11:8]}, 32'hE);
    check("d2_err_clr", {31'd0, code_err[2]}, 32'h0);

    // Reset in the middle of a dwell forces a full new dwell
    hold(7'h66, 4'b1000, 4);
    do_reset();
    upd_seen = 0;
    hold(7'h66, 4'b1000, 4);
    check("rst_no_early_upd", upd_seen, 0);
    hold(7'h66, 4'b1000, 4);
    check("rst_full_dwell", upd_seen, 1);

    // Randomized dwells
    for (int n = 0; n < 300; n++) begin
      int         d, kind, len;
      logic [6:0] sv;
      logic [3:0] ev;
      d    = $urandom_range(0, ND - 1);
      kind = $urandom_range(0, 9);
      if (kind == 0)      ev = 4'($urandom_range(0, 15));
      else if (kind == 1) ev = 4'h0;
      else                ev = 4'(1 << d);
      if ($urandom_range(0, 9) < 7) sv = codes[$urandom_range(0, 15)];
      else                          sv = 7'($urandom_range(0, 127));
      len = $urandom_range(1, 7);
      hold(sv, ev, len);
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
